instruction_fetch_queue: RTL
============================

// Module: instruction_fetch_queue
// PURPOSE
//  Fetch stage between program_memory and the decoders/control_unit. Issues word-address reads
//  (sequential, step 1), buffers returned instructions with their addresses in a DEPTH-entry FIFO,
//  presents them with a valid/ready handshake, and flushes on a redirect (jump/branch) from the PC.
// PARAMETERS
//  DEPTH       4   FIFO entries (power of two, >=2)
//  ADR_WIDTH   32  instruction word-address width
//  INST_WIDTH  32  instruction width
//  RESET_ADR   0   first fetch address after reset
// PORTS
//  clock           in   1          single clock, all state on rising edge
//  reset           in   1          asynchronous, active-high; clears all state
//  mem_req         out  1          read request to program memory this cycle
//  mem_adr         out  ADR_WIDTH  word address of request
//  mem_rvalid      in   1          read data valid; exactly 1 cycle after mem_req
//  mem_rdata       in   INST_WIDTH returned instruction
//  inst_valid      out  1          instruction/inst_adr valid to consumer
//  instruction     out  INST_WIDTH head-of-queue instruction
//  inst_adr        out  ADR_WIDTH  address of head instruction
//  inst_ready      in   1          consumer accepts head when inst_valid=1
//  redirect_valid  in   1          discard everything, restart at redirect_adr
//  redirect_adr    in   ADR_WIDTH  new fetch address
//  queue_count     out  clog2(DEPTH)+1  entries held (excludes in-flight)
// BEHAVIOUR
//  Reset: mem_req=0, mem_adr=RESET_ADR, inst_valid=0, instruction=0, inst_adr=0, queue_count=0,
//   fetch_adr=RESET_ADR, inflight=0, drop=0, state=FETCH. Reset mid-operation aborts immediately.
//  Credit: request issued only if queue_count + inflight < DEPTH (registered values, no pop lookahead).
//  FSM: FETCH -> mem_req=1 while credit; fetch_adr+=1 per issued request; no credit -> HOLD.
//   HOLD -> mem_req=0; credit available -> FETCH (request issued in that same cycle).
//   Any state + redirect_valid -> FLUSH. FLUSH -> mem_req=0 for one cycle, then FETCH.
//  Redirect edge: FIFO cleared (count=0, inst_valid=0 next cycle), fetch_adr<=redirect_adr,
//   drop<=inflight. Response arriving while drop=1 is discarded and drop clears.
//  Response: mem_rvalid && inflight && !drop -> push {mem_rdata, adr} at tail.
//  Latency: request cycle N, response N+1, inst_valid in N+2 (queue previously empty).
//  Pop: inst_valid && inst_ready -> head advances at edge; push+pop same cycle keeps count.
//  Throughput: 1 instruction/cycle sustained with inst_ready held high.
//  Simultaneous: redirect beats pop and push (both ignored); redirect during FLUSH re-targets
//   fetch_adr, stays FLUSH one more cycle.
//  Arithmetic: fetch_adr wraps modulo 2^ADR_WIDTH (all-ones -> 0); FIFO pointers wrap mod DEPTH.
//  Empty: inst_valid=0, instruction/inst_adr hold last value; full: never overflows by credit rule.
//  mem_rvalid with inflight=0 is ignored.
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when FIFO empty (or popping its last entry) and a valid non-dropped
//   response arrives, it drives instruction/inst_adr/inst_valid combinationally that cycle; if
//   inst_ready=1 it is consumed and not pushed. Latency request->inst_valid = 1 cycle.
//   Redirect cycle suppresses bypass (inst_valid=0).
//  Undefined: all responses go through FIFO; latency 2 cycles; outputs purely registered.
// TESTING
//  1 Memory word[i]=0x100+i, inst_ready=1, release reset -> mem_adr 0,1,2..; first inst_valid
//    2 cycles after first mem_req with instruction=0x100, inst_adr=0; then one per cycle in order.
//  2 inst_ready=0 -> exactly 4 requests, mem_req drops, queue_count=4, head 0x100 stable;
//    inst_ready=1 -> 0x100..0x103 drain in 4 cycles, mem_req reasserts next cycle with mem_adr=4.
//  3 Queue holds 3, request in flight, redirect_valid with redirect_adr=0x40 -> next cycle
//    inst_valid=0, queue_count=0, mem_req=0; following cycle mem_adr=0x40; no stale word ever
//    appears; first output inst_adr=0x40, instruction=0x140.
//  4 redirect_valid and inst_ready same cycle with head 0x102 -> head not counted consumed,
//    queue flushed, output resumes at redirect target only.
//  5 redirect_adr=0xFFFFFFFF -> outputs inst_adr 0xFFFFFFFF then 0x00000000.
//  6 reset pulsed mid-stream (no clock edge) -> inst_valid=0, mem_req=0 immediately; after
//    release fetch restarts at RESET_ADR. Repeat 1 with FETCH_BYPASS_EN: latency 1 cycle.

Source files
------------

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues sequential word reads to program memory, buffers the
// returned instructions with their addresses in a DEPTH-entry FIFO and hands them to the
// consumer over a valid/ready handshake. A redirect flushes everything and restarts fetch.
// Optional build macro: FETCH_BYPASS_EN lets a response that meets an empty FIFO drive the
// outputs combinationally in its arrival cycle.
module instruction_fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADR_WIDTH  = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter logic [ADR_WIDTH-1:0] RESET_ADR = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       mem_req,
    output logic [ADR_WIDTH-1:0]       mem_adr,
    input  logic                       mem_rvalid,
    input  logic [INST_WIDTH-1:0]      mem_rdata,
    output logic                       inst_valid,
    output logic [INST_WIDTH-1:0]      instruction,
    output logic [ADR_WIDTH-1:0]       inst_adr,
    input  logic                       inst_ready,
    input  logic                       redirect_valid,
    input  logic [ADR_WIDTH-1:0]       redirect_adr,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_W = DEPTH[CNT_W:0];

    typedef enum logic [1:0] {StFetch, StHold, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   fetch_adr_q, fetch_adr_d;
    logic [ADR_WIDTH-1:0]   req_adr_q;
    logic                   inflight_q;
    logic                   drop_q, drop_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [INST_WIDTH-1:0]  inst_mem_q [DEPTH];
    logic [ADR_WIDTH-1:0]   adr_mem_q  [DEPTH];
    logic [INST_WIDTH-1:0]  last_inst_q;
    logic [ADR_WIDTH-1:0]   last_adr_q;

    logic [CNT_W:0]         used_slots;
    logic                   credit;
    logic                   resp_ok;
    logic                   fifo_valid;
    logic                   bypass;
    logic                   push;
    logic                   pop;

    // Request, response and handshake decode for the current cycle.
    always_comb begin
        // Credit uses registered occupancy only; a pop this cycle frees a slot next cycle.
        used_slots = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        credit     = used_slots < DEPTH_W;
        // Reset gates the request combinationally so it drops without waiting for a clock.
        mem_req    = !reset && (state_q != StFlush) && credit;
        mem_adr    = fetch_adr_q;
        resp_ok    = mem_rvalid && inflight_q && !drop_q;
        fifo_valid = count_q != '0;
`ifdef FETCH_BYPASS_EN
        bypass     = !fifo_valid && resp_ok && !redirect_valid;
`else
        bypass     = 1'b0;
`endif
        inst_valid = fifo_valid || bypass;
        if (fifo_valid) begin
            instruction = inst_mem_q[rd_ptr_q];
            inst_adr    = adr_mem_q[rd_ptr_q];
        end else if (bypass) begin
            instruction = mem_rdata;
            inst_adr    = req_adr_q;
        end else begin
            instruction = last_inst_q;
            inst_adr    = last_adr_q;
        end
        // A redirect discards both the head and the arriving response.
        pop         = fifo_valid && inst_ready && !redirect_valid;
        push        = resp_ok && !redirect_valid && !(bypass && inst_ready);
        queue_count = count_q;
    end

    // Next-state for the fetch FSM, fetch address, drop flag and FIFO bookkeeping.
    always_comb begin
        state_d     = state_q;
        fetch_adr_d = fetch_adr_q;
        drop_d      = drop_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        unique case (state_q)
            StFetch: state_d = credit ? StFetch : StHold;
            StHold:  state_d = credit ? StFetch : StHold;
            StFlush: state_d = StFetch;
            default: state_d = StFetch;
        endcase

        if (mem_req) begin
            fetch_adr_d = fetch_adr_q + 1'b1;
        end

        // The only response still owed after a redirect is for a request issued this cycle.
        if (mem_rvalid && inflight_q && drop_q) begin
            drop_d = 1'b0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (redirect_valid) begin
            state_d     = StFlush;
            fetch_adr_d = redirect_adr;
            drop_d      = mem_req;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StFetch;
            fetch_adr_q <= RESET_ADR;
            req_adr_q   <= '0;
            inflight_q  <= 1'b0;
            drop_q      <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_adr_q <= fetch_adr_d;
            inflight_q  <= mem_req;
            drop_q      <= drop_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            if (mem_req) begin
                req_adr_q <= fetch_adr_q;
            end
        end
    end

    // FIFO storage, written at the tail on push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                adr_mem_q[i]  <= '0;
            end
        end else if (push) begin
            inst_mem_q[wr_ptr_q] <= mem_rdata;
            adr_mem_q[wr_ptr_q]  <= req_adr_q;
        end
    end

    // Remember the last presented instruction so the outputs hold while the queue is empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_inst_q <= '0;
            last_adr_q  <= '0;
        end else if (inst_valid) begin
            last_inst_q <= instruction;
            last_adr_q  <= inst_adr;
        end
    end

endmodule
